// File: rtl/batch_builder.sv
// batch_builder: groups mutually non-conflicting transactions into batches and drains each batch as an AXIS packet.
// Macro BATCH_BUILDER_PERF_COUNTERS_EN instantiates the saturating perf counters; otherwise they read as 0.
module batch_builder #(
  parameter int MAX_BATCH_SIZE       = 8,
  parameter int BATCH_TIMEOUT_CYCLES = 64,
  parameter int DEP_WIDTH            = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [63:0]          s_axis_tdata_owner_programID,
  input  logic [DEP_WIDTH-1:0] s_axis_tdata_read_dependencies,
  input  logic [DEP_WIDTH-1:0] s_axis_tdata_write_dependencies,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [63:0]          m_axis_tdata_owner_programID,
  output logic [DEP_WIDTH-1:0] m_axis_tdata_read_dependencies,
  output logic [DEP_WIDTH-1:0] m_axis_tdata_write_dependencies,
  output logic [15:0]          m_axis_tuser_batch_id,
  output logic [31:0]          batch_count,
  output logic [31:0]          conflict_close_count,
  output logic [31:0]          timeout_close_count
);

  localparam int IW = (MAX_BATCH_SIZE > 1) ? $clog2(MAX_BATCH_SIZE) : 1;
  localparam int CW = $clog2(MAX_BATCH_SIZE + 1);
  localparam int TW = (BATCH_TIMEOUT_CYCLES > 1) ? $clog2(BATCH_TIMEOUT_CYCLES) : 1;
  localparam logic [TW:0] TIMER_LIMIT = (TW+1)'(BATCH_TIMEOUT_CYCLES - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [63:0]          r_bufId [MAX_BATCH_SIZE];
  logic [DEP_WIDTH-1:0] r_bufR  [MAX_BATCH_SIZE];
  logic [DEP_WIDTH-1:0] r_bufW  [MAX_BATCH_SIZE];
  logic [CW-1:0]        r_count;
  logic [IW-1:0]        r_rdIdx;
  logic [TW-1:0]        r_timer;
  logic [DEP_WIDTH-1:0] r_accR;
  logic [DEP_WIDTH-1:0] r_accW;
  logic [15:0]          r_batchId;
  logic [TW:0]          w_timerNext;
  logic                 w_conflict;
  logic                 w_accept;
  logic                 w_fullClose;
  logic                 w_conflictClose;
  logic                 w_timeoutClose;
  logic                 w_lastBeat;
  logic                 w_drainHs;
  logic                 w_drainDone;

  assign w_conflict  = (|(s_axis_tdata_write_dependencies & (r_accR | r_accW))) |
                       (|(s_axis_tdata_read_dependencies & r_accW));
  assign w_timerNext = {1'b0, r_timer} + (TW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_nextState;
  end

  // A conflicting beat is refused and left upstream; it closes the batch instead.
  always_comb begin
    w_nextState     = r_state;
    s_axis_tready   = 1'b0;
    w_accept        = 1'b0;
    w_fullClose     = 1'b0;
    w_conflictClose = 1'b0;
    w_timeoutClose  = 1'b0;
    w_lastBeat      = 1'b0;
    w_drainHs       = 1'b0;
    w_drainDone     = 1'b0;
    case (r_state)
      COLLECT: begin
        s_axis_tready = !(s_axis_tvalid && w_conflict);
        w_accept      = s_axis_tvalid && s_axis_tready;
        if (w_accept && (r_count == CW'(MAX_BATCH_SIZE - 1)))
          w_fullClose = 1'b1;
        else if (s_axis_tvalid && w_conflict && (r_count != '0))
          w_conflictClose = 1'b1;
        else if (!w_accept && (r_count != '0) && (w_timerNext >= TIMER_LIMIT))
          w_timeoutClose = 1'b1;
        if (w_fullClose || w_conflictClose || w_timeoutClose)
          w_nextState = DRAIN;
      end
      DRAIN: begin
        w_lastBeat  = (CW'(r_rdIdx) == (r_count - CW'(1)));
        w_drainHs   = m_axis_tready;
        w_drainDone = m_axis_tready && w_lastBeat;
        if (w_drainDone)
          w_nextState = COLLECT;
      end
      default: w_nextState = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bufId[r_count[IW-1:0]] <= s_axis_tdata_owner_programID;
      r_bufR[r_count[IW-1:0]]  <= s_axis_tdata_read_dependencies;
      r_bufW[r_count[IW-1:0]]  <= s_axis_tdata_write_dependencies;
    end
  end

  // The idle timer only runs while a non-empty batch waits in COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_rdIdx   <= '0;
      r_timer   <= '0;
      r_accR    <= '0;
      r_accW    <= '0;
      r_batchId <= '0;
    end else begin
      if (w_accept || w_conflictClose || w_timeoutClose || (r_state == DRAIN))
        r_timer <= '0;
      else if (r_count != '0)
        r_timer <= w_timerNext[TW-1:0];

      if (w_accept) begin
        r_accR  <= r_accR | s_axis_tdata_read_dependencies;
        r_accW  <= r_accW | s_axis_tdata_write_dependencies;
        r_count <= r_count + CW'(1);
      end else if (w_drainDone) begin
        r_count   <= '0;
        r_rdIdx   <= '0;
        r_accR    <= '0;
        r_accW    <= '0;
        r_batchId <= r_batchId + 16'd1;
      end else if (w_drainHs) begin
        r_rdIdx <= r_rdIdx + IW'(1);
      end
    end
  end

  assign m_axis_tvalid                   = (r_state == DRAIN);
  assign m_axis_tlast                    = w_lastBeat;
  assign m_axis_tdata_owner_programID    = m_axis_tvalid ? r_bufId[r_rdIdx] : '0;
  assign m_axis_tdata_read_dependencies  = m_axis_tvalid ? r_bufR[r_rdIdx]  : '0;
  assign m_axis_tdata_write_dependencies = m_axis_tvalid ? r_bufW[r_rdIdx]  : '0;
  assign m_axis_tuser_batch_id           = r_batchId;

`ifdef BATCH_BUILDER_PERF_COUNTERS_EN
  logic [31:0] r_batchCount;
  logic [31:0] r_conflictCount;
  logic [31:0] r_timeoutCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_batchCount    <= '0;
      r_conflictCount <= '0;
      r_timeoutCount  <= '0;
    end else begin
      if (w_drainDone && (r_batchCount != '1))
        r_batchCount <= r_batchCount + 32'd1;
      if (w_conflictClose && (r_conflictCount != '1))
        r_conflictCount <= r_conflictCount + 32'd1;
      if (w_timeoutClose && (r_timeoutCount != '1))
        r_timeoutCount <= r_timeoutCount + 32'd1;
    end
  end

  assign batch_count          = r_batchCount;
  assign conflict_close_count = r_conflictCount;
  assign timeout_close_count  = r_timeoutCount;
`else
  assign batch_count          = '0;
  assign conflict_close_count = '0;
  assign timeout_close_count  = '0;
`endif

endmodule

// File: tb/tb_batch_builder.sv
// tb_batch_builder: directed scenarios plus randomized traffic checked against a queue-based batch model.
// Expected perf counter values follow BATCH_BUILDER_PERF_COUNTERS_EN.
module tb_batch_builder;

  localparam int MAXB = 8;
  localparam int TOUT = 64;
  localparam int DW   = 1024;
  localparam int IDLE_TO_CLOSE = (TOUT > 1) ? (TOUT - 1) : 1;
`ifdef BATCH_BUILDER_PERF_COUNTERS_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0]   id;
    logic [DW-1:0] r;
    logic [DW-1:0] w;
    int            gap;
  } txn_t;

  typedef struct {
    logic [63:0] id;
    bit          last;
    logic [15:0] bid;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [63:0] id;
    int          cyc;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [63:0]   s_id;
  logic [DW-1:0] s_r;
  logic [DW-1:0] s_w;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [63:0]   m_id;
  logic [DW-1:0] m_r;
  logic [DW-1:0] m_w;
  logic [15:0]   m_bid;
  logic [31:0]   batch_count;
  logic [31:0]   conflict_close_count;
  logic [31:0]   timeout_close_count;

  batch_builder #(
    .MAX_BATCH_SIZE(MAXB),
    .BATCH_TIMEOUT_CYCLES(TOUT),
    .DEP_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata_owner_programID(s_id),
    .s_axis_tdata_read_dependencies(s_r),
    .s_axis_tdata_write_dependencies(s_w),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata_owner_programID(m_id),
    .m_axis_tdata_read_dependencies(m_r),
    .m_axis_tdata_write_dependencies(m_w),
    .m_axis_tuser_batch_id(m_bid),
    .batch_count(batch_count),
    .conflict_close_count(conflict_close_count),
    .timeout_close_count(timeout_close_count)
  );

  always #5 clk = ~clk;

  int    checkCount = 0;
  int    passCount  = 0;
  int    cycleNum   = 0;
  txn_t  txQ[$];
  bit    readyQ[$];
  bit    readyRandom = 1'b0;
  bit    drvValid = 1'b0;
  txn_t  drvTxn;
  beat_t outLog[$];
  acc_t  accLog[$];

  // Reference model: the open batch as a list of members plus drain progress.
  txn_t        batchQ[$];
  bit          mDrain = 1'b0;
  int          mIdle = 0;
  int          mOutIdx = 0;
  logic [15:0] mBatchId = '0;
  int          mBatchCnt = 0;
  int          mConflictCnt = 0;
  int          mTimeoutCnt = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  function automatic bit modelConflict(input txn_t t);
    foreach (batchQ[k])
      if ((|(t.w & (batchQ[k].r | batchQ[k].w))) || (|(t.r & batchQ[k].w))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic txn_t makeTxn(input logic [63:0] id, input int rBit, input int wBit, input int gap);
    txn_t t;
    t.id  = id;
    t.r   = '0;
    t.w   = '0;
    t.gap = gap;
    if (rBit >= 0) t.r[rBit] = 1'b1;
    if (wBit >= 0) t.w[wBit] = 1'b1;
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t t;
    t.id = {$urandom, $urandom};
    t.r  = '0;
    t.w  = '0;
    repeat ($urandom_range(0, 2)) t.r[$urandom_range(0, 23)] = 1'b1;
    if ($urandom_range(0, 1) == 1) t.w[$urandom_range(0, 23)] = 1'b1;
    if ($urandom_range(0, 9) == 0) t.r[$urandom_range(24, DW-1)] = 1'b1;
    case ($urandom_range(0, 15))
      0:       t.gap = int'($urandom_range(60, 70));
      1, 2, 3: t.gap = int'($urandom_range(1, 4));
      default: t.gap = 0;
    endcase
    return t;
  endfunction

  task automatic stepCycle();
    bit conf;
    @(negedge clk);
    if (!drvValid && txQ.size() > 0) begin
      if (txQ[0].gap > 0) txQ[0].gap = txQ[0].gap - 1;
      else begin
        drvTxn   = txQ.pop_front();
        drvValid = 1'b1;
      end
    end
    s_axis_tvalid = drvValid;
    s_id = drvValid ? drvTxn.id : '0;
    s_r  = drvValid ? drvTxn.r  : '0;
    s_w  = drvValid ? drvTxn.w  : '0;
    if (mDrain && readyQ.size() > 0) m_axis_tready = readyQ.pop_front();
    else if (readyRandom)            m_axis_tready = ($urandom_range(0, 3) != 0);
    else                             m_axis_tready = 1'b1;
    #1;
    conf = drvValid && modelConflict(drvTxn);
    checkOutput("s_tready", 64'(s_axis_tready), 64'(!mDrain && !conf));
    checkOutput("m_tvalid", 64'(m_axis_tvalid), 64'(mDrain));
    if (mDrain) begin
      checkOutput("m_tlast", 64'(m_axis_tlast), 64'(mOutIdx == batchQ.size() - 1));
      checkOutput("m_id", m_id, batchQ[mOutIdx].id);
      checkOutput("m_rdeps_equal", 64'(m_r === batchQ[mOutIdx].r), 64'd1);
      checkOutput("m_wdeps_equal", 64'(m_w === batchQ[mOutIdx].w), 64'd1);
      checkOutput("m_batch_id", 64'(m_bid), 64'(mBatchId));
    end
    checkOutput("batch_count", 64'(batch_count), PERF_EN ? 64'(mBatchCnt) : 64'd0);
    checkOutput("conflict_cnt", 64'(conflict_close_count), PERF_EN ? 64'(mConflictCnt) : 64'd0);
    checkOutput("timeout_cnt", 64'(timeout_close_count), PERF_EN ? 64'(mTimeoutCnt) : 64'd0);
    if (m_axis_tvalid && m_axis_tready) outLog.push_back('{m_id, m_axis_tlast, m_bid, cycleNum});
    if (s_axis_tvalid && s_axis_tready) accLog.push_back('{drvTxn.id, cycleNum});
    if (!mDrain) begin
      if (drvValid && !conf) begin
        batchQ.push_back(drvTxn);
        mIdle = 0;
        if (batchQ.size() == MAXB) mDrain = 1'b1;
      end else if (conf) begin
        mDrain = 1'b1;
        mIdle  = 0;
        mConflictCnt++;
      end else if (batchQ.size() > 0) begin
        mIdle++;
        if (mIdle >= IDLE_TO_CLOSE) begin
          mDrain = 1'b1;
          mIdle  = 0;
          mTimeoutCnt++;
        end
      end
    end else if (m_axis_tready) begin
      if (mOutIdx == batchQ.size() - 1) begin
        batchQ.delete();
        mOutIdx  = 0;
        mBatchId = mBatchId + 16'd1;
        mBatchCnt++;
        mDrain = 1'b0;
      end else mOutIdx++;
    end
    if (drvValid && s_axis_tready) drvValid = 1'b0;
    cycleNum++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int maxCycles);
    int n = 0;
    while ((txQ.size() > 0 || drvValid || batchQ.size() > 0 || mDrain) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput("run_bound", 64'(n < maxCycles), 64'd1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_id = '0;
    s_r  = '0;
    s_w  = '0;
    m_axis_tready = 1'b0;
    drvValid = 1'b0;
    readyRandom = 1'b0;
    txQ.delete();
    readyQ.delete();
    batchQ.delete();
    outLog.delete();
    accLog.delete();
    mDrain = 1'b0;
    mIdle = 0;
    mOutIdx = 0;
    mBatchId = '0;
    mBatchCnt = 0;
    mConflictCnt = 0;
    mTimeoutCnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    doReset();
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_m_id", m_id, 64'd0);
    checkOutput("rst_s_tready", 64'(s_axis_tready), 64'd1);
    checkOutput("rst_batch_id", 64'(m_bid), 64'd0);
    checkOutput("rst_batch_count", 64'(batch_count), 64'd0);

    $display("[TB] full close");
    for (int i = 0; i < 8; i++) txQ.push_back(makeTxn(64'(i + 1), -1, i, 0));
    applyStimulus(500);
    checkOutput("full_beats", 64'(outLog.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < outLog.size()) begin
        checkOutput("full_id", outLog[i].id, 64'(i + 1));
        checkOutput("full_last", 64'(outLog[i].last), 64'(i == 7));
        checkOutput("full_bid", 64'(outLog[i].bid), 64'd0);
      end
    checkOutput("full_batch_count", 64'(batch_count), PERF_EN ? 64'd1 : 64'd0);

    $display("[TB] conflict close");
    doReset();
    txQ.push_back(makeTxn(64'hA, -1, 5, 0));
    txQ.push_back(makeTxn(64'hB, 5, -1, 0));
    applyStimulus(500);
    checkOutput("conf_beats", 64'(outLog.size()), 64'd2);
    if (outLog.size() == 2 && accLog.size() == 2) begin
      checkOutput("conf_first_id", outLog[0].id, 64'hA);
      checkOutput("conf_first_last", 64'(outLog[0].last), 64'd1);
      checkOutput("conf_second_id", outLog[1].id, 64'hB);
      checkOutput("conf_second_bid", 64'(outLog[1].bid), 64'd1);
      checkOutput("conf_accept_gap", 64'(accLog[1].cyc - outLog[0].cyc), 64'd1);
    end
    checkOutput("conf_count", 64'(conflict_close_count), PERF_EN ? 64'd1 : 64'd0);

    $display("[TB] timeout close");
    doReset();
    txQ.push_back(makeTxn(64'h3, -1, 9, 0));
    applyStimulus(500);
    if (outLog.size() > 0 && accLog.size() > 0)
      checkOutput("timeout_latency", 64'(outLog[0].cyc - accLog[0].cyc), 64'(TOUT));
    checkOutput("timeout_count", 64'(timeout_close_count), PERF_EN ? 64'd1 : 64'd0);

    $display("[TB] read-read sharing");
    doReset();
    for (int i = 0; i < 3; i++) txQ.push_back(makeTxn(64'h21 + 64'(i), 100, -1, 0));
    applyStimulus(500);
    checkOutput("rr_beats", 64'(outLog.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < outLog.size()) begin
        checkOutput("rr_bid", 64'(outLog[i].bid), 64'd0);
        checkOutput("rr_last", 64'(outLog[i].last), 64'(i == 2));
      end

    $display("[TB] backpressure");
    doReset();
    for (int i = 0; i < 3; i++) txQ.push_back(makeTxn(64'h31 + 64'(i), -1, 40 + i, 0));
    readyQ = '{1'b1, 1'b0, 1'b0, 1'b1};
    applyStimulus(500);
    checkOutput("bp_beats", 64'(outLog.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < outLog.size()) begin
        checkOutput("bp_id", outLog[i].id, 64'h31 + 64'(i));
        checkOutput("bp_last", 64'(outLog[i].last), 64'(i == 2));
      end
    if (outLog.size() == 3) checkOutput("bp_stall_span", 64'(outLog[1].cyc - outLog[0].cyc), 64'd3);

    $display("[TB] reset mid-drain");
    doReset();
    for (int i = 0; i < 4; i++) txQ.push_back(makeTxn(64'h41 + 64'(i), -1, 60 + i, 0));
    for (int n = 0; n < 500 && outLog.size() == 0; n++) stepCycle();
    checkOutput("mid_first_beat", 64'(outLog.size()), 64'd1);
    checkOutput("mid_tvalid_before", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_tvalid_in_reset", 64'(m_axis_tvalid), 64'd0);
    checkOutput("mid_tlast_in_reset", 64'(m_axis_tlast), 64'd0);
    doReset();
    checkOutput("mid_s_tready", 64'(s_axis_tready), 64'd1);
    checkOutput("mid_batch_id", 64'(m_bid), 64'd0);
    checkOutput("mid_tvalid_after", 64'(m_axis_tvalid), 64'd0);

    $display("[TB] randomized traffic");
    doReset();
    readyRandom = 1'b1;
    for (int i = 0; i < 300; i++) txQ.push_back(randTxn());
    applyStimulus(40000);
    checkOutput("rand_beats", 64'(outLog.size()), 64'd300);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
